// File: rtl/sdram_arbiter.sv
// Four-way arbiter in front of the 8-bit SDRAM controller: download, cleanup,
// CPU and cassette accesses are sequenced one at a time through a strobe/done handshake.
module sdram_arbiter #(
    parameter int TIMEOUT     = 64,
    parameter int CAS_MAXWAIT = 15
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_req,
    input  logic        dl_rom,
    input  logic        dl_slot,
    input  logic [20:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_ack,
    input  logic        cl_req,
    input  logic [15:0] cl_addr,
    output logic        cl_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    input  logic        cas_req,
    input  logic [20:0] cas_addr,
    input  logic        cas_window,
    output logic        cas_ack,
    output logic [7:0]  rdata,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_we,
    input  logic        mem_done,
    input  logic [7:0]  mem_rdata,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(CAS_MAXWAIT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(CAS_MAXWAIT);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {SRC_DL = 2'd0, SRC_CL = 2'd1, SRC_CPU = 2'd2, SRC_CAS = 2'd3} src_t;

    state_t        state_q, state_d;
    src_t          src_q, src_d;
    logic          we_q, we_d;
    logic [22:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_q, err_d;
    logic [3:0]    ack_q, ack_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_we_q, mem_we_d;
    logic          cas_elig_s, cas_boost_s, grant_s;

    // Next-state, grant selection and completion handling
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        timer_d     = timer_q;
        starve_d    = starve_q;
        err_d       = err_q;
        ack_d       = 4'b0000;
        mem_rd_d    = 1'b0;
        mem_we_d    = 1'b0;
        grant_s     = 1'b0;
        cas_elig_s  = cas_req & cas_window;
        cas_boost_s = cas_elig_s && (starve_q == STARVE_MAX);

        case (state_q)
            ST_IDLE: begin
                if (dl_req) begin
                    grant_s = 1'b1;
                    src_d   = SRC_DL;
                    we_d    = 1'b1;
                    wdata_d = dl_data;
                    addr_d  = dl_rom ? {6'd0, dl_slot, dl_addr[15:0]} : {2'b11, dl_addr};
                end else if (cl_req) begin
                    grant_s = 1'b1;
                    src_d   = SRC_CL;
                    we_d    = 1'b1;
                    wdata_d = 8'h00;
                    addr_d  = {7'd1, cl_addr};
                end else if (cas_boost_s) begin
                    // Starved cassette reader gets one grant ahead of the CPU
                    grant_s  = 1'b1;
                    src_d    = SRC_CAS;
                    we_d     = 1'b0;
                    addr_d   = {2'b11, cas_addr};
                    starve_d = {SW{1'b0}};
                end else if (cpu_req) begin
                    grant_s = 1'b1;
                    src_d   = SRC_CPU;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    addr_d  = {5'd0, cpu_addr};
                    if (cas_elig_s && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else if (cas_elig_s) begin
                    grant_s  = 1'b1;
                    src_d    = SRC_CAS;
                    we_d     = 1'b0;
                    addr_d   = {2'b11, cas_addr};
                    starve_d = {SW{1'b0}};
                end else begin
                    grant_s = 1'b0;
                end

                if (grant_s) begin
                    state_d  = ST_ISSUE;
                    mem_rd_d = ~we_d;
                    mem_we_d = we_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                timer_d = {TW{1'b0}};
            end
            ST_WAIT: begin
                if (mem_done) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    ack_d   = 4'b0001 << src_q;
                    state_d = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    // Abort: the requester still gets its ack, reads return all-ones
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 8'hFF;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    ack_d   = 4'b0001 << src_q;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_DL;
            we_q     <= 1'b0;
            addr_q   <= 23'd0;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            timer_q  <= {TW{1'b0}};
            starve_q <= {SW{1'b0}};
            err_q    <= 1'b0;
            ack_q    <= 4'b0000;
            mem_rd_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            timer_q  <= timer_d;
            starve_q <= starve_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            mem_rd_q <= mem_rd_d;
            mem_we_q <= mem_we_d;
        end
    end

    assign dl_ack    = ack_q[0];
    assign cl_ack    = ack_q[1];
    assign cpu_ack   = ack_q[2];
    assign cas_ack   = ack_q[3];
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_we    = mem_we_q;
    assign err       = err_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single 8-bit SDRAM port between four requesters: the ioctl download path (ROM and CAS images), the hard-reset cleanup sweep, the CPU RAM window, and the cassette reader.
- Forms the full 23-bit SDRAM address for each source and sequences one access at a time through a request/done handshake.
- Returns read data and a per-requester acknowledge.
- Sits between the data_io / console / cassette blocks and the sdram controller.

Parameters:
TIMEOUT, 64, cycles to wait for mem_done before aborting an access
CAS_MAXWAIT, 15, number of lost CPU-vs-CAS arbitrations after which CAS gets one-shot priority

Ports:
clk_sys  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
dl_req  in  1  download write request (level, held until dl_ack)
dl_rom  in  1  1 = ROM image, 0 = CAS image
dl_slot  in  1  ROM slot (ioctl_index[0])
dl_addr  in  21  download byte address
dl_data  in  8  download write byte
dl_ack  out  1  one-cycle completion pulse
cl_req  in  1  cleanup write request
cl_addr  in  16  cleanup address
cl_ack  out  1  completion pulse
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  18  mapped RAM address
cpu_wdata  in  8  CPU write byte
cpu_ack  out  1  completion pulse
cas_req  in  1  cassette read request
cas_addr  in  21  cassette byte address
cas_window  in  1  CAS may only be granted while high (CPU refresh)
cas_ack  out  1  completion pulse
rdata  out  8  read data, valid in ack cycle
mem_addr  out  23  SDRAM address
mem_wdata  out  8  SDRAM write data
mem_rd  out  1  one-cycle read strobe
mem_we  out  1  one-cycle write strobe
mem_done  in  1  one-cycle completion from controller; read data on mem_rdata
mem_rdata  in  8  controller read data
err  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release): state IDLE; all acks, mem_rd, mem_we, err = 0; rdata = 8'h00; mem_addr = 0; mem_wdata = 0; starve counter = 0.
- Address map:
  - dl ROM: {6'd0, dl_slot, dl_addr[15:0]}
  - dl CAS: {2'b11, dl_addr}
  - cleanup: {7'd1, cl_addr}, i.e. bit 16 set (numeric value {1'b1, cl_addr})
  - CPU: {5'd0, cpu_addr}
  - CAS: {2'b11, cas_addr}
- Requests dl and cl are always writes; CAS is always a read; CPU direction is given by cpu_we.
- Priority in IDLE: dl > cl > cpu > cas.
  - cas is eligible only when cas_req & cas_window.
- Starvation: each time cas is eligible and the CPU is granted instead, the starve counter increments (saturating at CAS_MAXWAIT).
  - At CAS_MAXWAIT, cas outranks the CPU (not dl/cl) for the next grant, and the counter clears.
  - The counter also clears on any cas grant.
- FSM:
  - IDLE: on any eligible request, latch source, address, write data and direction; go to ISSUE.
  - ISSUE (1 cycle): pulse mem_rd or mem_we with mem_addr/mem_wdata stable; go to WAIT with the timer cleared.
  - WAIT: on mem_done, capture mem_rdata into rdata (reads only; writes leave rdata unchanged), pulse the latched source's ack, go to IDLE. Timer reaching TIMEOUT-1 without mem_done: set err, rdata = 8'hFF for reads, pulse ack, go to IDLE.
- Latency: request seen in IDLE at cycle N, strobe at N+1, ack in the cycle after mem_done. Minimum ack at N+3 with a 1-cycle controller.
- mem_addr and mem_wdata hold their latched values from ISSUE until the next grant.
- Exactly one ack per access; at most one ack high per cycle. A requester dropping req during WAIT still gets its ack, and the access completes.
- A new grant requires returning to IDLE, so back-to-back accesses cost at least one IDLE cycle.
- mem_done outside WAIT is ignored.
- cas_window falling during WAIT does not abort an in-flight CAS read.
- err clears only on reset.

Test Plan:
- CPU read cpu_addr=18'h01234, controller done after 3 cycles with 8'h5A -> mem_addr=23'h001234, mem_rd single pulse, cpu_ack one cycle with rdata=8'h5A.
- dl_req (ROM, slot 1, addr 16'h0010, data 8'hC3) and cpu_req in the same cycle -> dl granted first with mem_addr=23'h010010 and mem_we; CPU granted on the next IDLE.
- cl_addr=16'hFFFF write -> mem_addr=23'h01FFFF, mem_wdata=8'h00 as driven; cl_ack follows mem_done.
- cas_req with cas_window=0 -> no grant; raise window -> read at {2'b11, cas_addr}; with continuous cpu_req, cas is granted after 15 lost arbitrations.
- No mem_done for 64 cycles on a CPU read -> cpu_ack pulse, rdata=8'hFF, err=1 and stays 1.
- reset_n low mid-WAIT -> outputs immediately zero, state IDLE; a late mem_done produces no ack.
